// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the cache and arbiter blocks
//
// Purpose: common enums and word type used by the cache controllers, the
//          memory arbiter and the RAM adapter.
// Contents:
//   ramstate_t  - RAM port status: FREE, BUSY, ACCESS, ERROR
//   word_t      - 32-bit machine word
//   arb_state_t - memory arbiter FSM state: ARB_IDLE, ARB_BUSY
//                 (prefixed so the names do not collide with ramstate_t BUSY)

package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rtl/memory_arbiter_rr_picker.sv - combinational round-robin request picker
//
// Purpose: returns the first set request found when searching
//          ptr, ptr+1, ... (mod N).
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index where the search starts (must be < N)
//   valid out 1   at least one request is set
//   idx   out IW  index of the selected request (0 when valid=0)

module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // Walk the search order backwards so the last hit written is the one
    // closest to ptr, i.e. the first one in round-robin order.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter of CPUS I/D caches onto one RAM port
//
// Purpose: grants one of N = 2*CPUS requesters (index 2c = data of CPU c,
//          2c+1 = instruction of CPU c) at a time; the grant is registered in
//          IDLE and held until the RAM reports ACCESS or the request drops.
// Option:  MEMARB_DPRIO_EN - when defined, data requests win over instruction
//          requests in IDLE (round-robin within each class).
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   iREN, iaddr     instruction read request / address per CPU
//   dREN, dWEN      data read / write request per CPU (write wins)
//   daddr, dstore   data address / write data per CPU
//   iwait, dwait    1 = access not complete (0 for one cycle on completion)
//   iload, dload    read data, valid only in the completion cycle
//   ramREN, ramWEN  RAM enables
//   ramaddr         RAM address
//   ramstore        RAM write data
//   ramload         RAM read data
//   ramstate        RAM status (ramstate_t)

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*ADDR_W-1:0] iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*ADDR_W-1:0] daddr,
  input  logic [CPUS*DATA_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*DATA_W-1:0] iload,
  output logic [CPUS*DATA_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  input  logic [DATA_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int N  = 2 * CPUS;
  localparam int IW = $clog2(N);

  localparam logic [0:0] ST_IDLE = ARB_IDLE;
  localparam logic [0:0] ST_BUSY = ARB_BUSY;

  logic [0:0]    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;

  logic [N-1:0]  req;
  logic [N-1:0]  d_req;
  logic [N-1:0]  i_req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          done;

  always_comb begin
    req   = '0;
    d_req = '0;
    i_req = '0;
    for (int c = 0; c < CPUS; c++) begin
      d_req[2*c]   = dREN[c] | dWEN[c];
      i_req[2*c+1] = iREN[c];
    end
    req = d_req | i_req;
  end

`ifdef MEMARB_DPRIO_EN
  logic          d_valid, i_valid;
  logic [IW-1:0] d_idx, i_idx;

  rr_picker #(.N(N), .IW(IW)) u_pick_d (
    .req(d_req), .ptr(rr_ptr), .valid(d_valid), .idx(d_idx)
  );
  rr_picker #(.N(N), .IW(IW)) u_pick_i (
    .req(i_req), .ptr(rr_ptr), .valid(i_valid), .idx(i_idx)
  );

  assign pick_valid = d_valid | i_valid;
  assign pick_idx   = d_valid ? d_idx : i_idx;
`else
  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req(req), .ptr(rr_ptr), .valid(pick_valid), .idx(pick_idx)
  );
`endif

  // A dropped request takes precedence over ACCESS: the transaction is
  // abandoned without a wait pulse.
  assign done = (state == ST_BUSY) && req[grant] && (ramstate == ACCESS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_idx;
            state <= ST_BUSY;
          end
        end
        default: begin
          if (!req[grant]) begin
            state <= ST_IDLE;
          end else if (ramstate == ACCESS) begin
            state  <= ST_IDLE;
            rr_ptr <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
          end
        end
      endcase
    end
  end

  // RAM side follows the granted requester's live inputs while BUSY, so a
  // read that turns into a write mid-access is reflected immediately.
  always_comb begin
    int gc;
    gc       = int'(grant) / 2;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state == ST_BUSY) begin
      if (grant[0]) begin
        ramREN  = iREN[gc];
        ramaddr = iaddr[gc*ADDR_W +: ADDR_W];
        if (done) begin
          iwait[gc]                 = 1'b0;
          iload[gc*DATA_W +: DATA_W] = ramload;
        end
      end else begin
        ramWEN   = dWEN[gc];
        ramREN   = dREN[gc] & ~dWEN[gc];
        ramaddr  = daddr[gc*ADDR_W +: ADDR_W];
        ramstore = dstore[gc*DATA_W +: DATA_W];
        if (done) begin
          dwait[gc] = 1'b0;
          if (!dWEN[gc]) dload[gc*DATA_W +: DATA_W] = ramload;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter

module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int N      = 2 * CPUS;

  logic                   CLK;
  logic                   RST;
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS*ADDR_W-1:0] iaddr, daddr;
  logic [CPUS*DATA_W-1:0] dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [CPUS*DATA_W-1:0] iload, dload;
  logic                   ramREN, ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore, ramload;
  logic [1:0]             ramstate;

  int tests = 0;
  int fails = 0;

  // Transaction-level reference: who currently owns the RAM (-1 = nobody)
  // and where the next round-robin search begins.
  int owner = -1;
  int m_ptr = 0;
  int pulse_log[$];

  memory_arbiter #(.CPUS(CPUS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic wants(int r);
    if (r % 2 == 0) return dREN[r/2] | dWEN[r/2];
    return iREN[r/2];
  endfunction

  task automatic check_cycle();
    logic                   e_ren, e_wen;
    logic [ADDR_W-1:0]      e_addr;
    logic [DATA_W-1:0]      e_store;
    logic [CPUS-1:0]        e_iwait, e_dwait;
    logic [CPUS*DATA_W-1:0] e_iload, e_dload;
    int c, npulse;
    e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
    e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0;
    if (owner >= 0) begin
      c = owner / 2;
      if (owner % 2 == 1) begin
        e_ren  = iREN[c];
        e_addr = iaddr[c*ADDR_W +: ADDR_W];
      end else begin
        e_wen   = dWEN[c];
        e_ren   = dREN[c] && !dWEN[c];
        e_addr  = daddr[c*ADDR_W +: ADDR_W];
        e_store = dstore[c*DATA_W +: DATA_W];
      end
      if (wants(owner) && ramstate == ACCESS) begin
        if (owner % 2 == 1) begin
          e_iwait[c] = 1'b0;
          e_iload[c*DATA_W +: DATA_W] = ramload;
        end else begin
          e_dwait[c] = 1'b0;
          if (!dWEN[c]) e_dload[c*DATA_W +: DATA_W] = ramload;
        end
      end
    end
    chk("ramREN", 64'(ramREN), 64'(e_ren));
    chk("ramWEN", 64'(ramWEN), 64'(e_wen));
    chk("ramaddr", 64'(ramaddr), 64'(e_addr));
    chk("ramstore", 64'(ramstore), 64'(e_store));
    chk("iwait", 64'(iwait), 64'(e_iwait));
    chk("dwait", 64'(dwait), 64'(e_dwait));
    chk("iload", 64'(iload), 64'(e_iload));
    chk("dload", 64'(dload), 64'(e_dload));
    npulse = 0;
    for (int k = 0; k < CPUS; k++) begin
      if (iwait[k] === 1'b0) begin npulse++; pulse_log.push_back(2*k+1); end
      if (dwait[k] === 1'b0) begin npulse++; pulse_log.push_back(2*k); end
    end
    chk("single_pulse", 64'(npulse <= 1), 64'd1);
  endtask

  // Advance the reference to what the next rising edge will do.
  task automatic model_edge();
    int r;
    if (owner < 0) begin
`ifdef MEMARB_DPRIO_EN
      for (int k = 0; k < N && owner < 0; k++) begin
        r = (m_ptr + k) % N;
        if (r % 2 == 0 && wants(r)) owner = r;
      end
      for (int k = 0; k < N && owner < 0; k++) begin
        r = (m_ptr + k) % N;
        if (r % 2 == 1 && wants(r)) owner = r;
      end
`else
      for (int k = 0; k < N && owner < 0; k++) begin
        r = (m_ptr + k) % N;
        if (wants(r)) owner = r;
      end
`endif
    end else if (!wants(owner)) begin
      owner = -1;
    end else if (ramstate == ACCESS) begin
      m_ptr = (owner + 1) % N;
      owner = -1;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    check_cycle();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    RST = 1'b0;
    owner = -1;
    m_ptr = 0;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    ramstate = FREE;
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    @(posedge CLK);
    #1;
    chk("rst_ramREN", 64'(ramREN), 64'd0);
    chk("rst_ramWEN", 64'(ramWEN), 64'd0);
    chk("rst_ramaddr", 64'(ramaddr), 64'd0);
    chk("rst_iwait", 64'(iwait), 64'h3);
    chk("rst_dwait", 64'(dwait), 64'h3);
    chk("rst_loads", 64'(iload | dload), 64'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Instruction read on CPU 0, RAM answers on the second BUSY cycle.
    iREN[0] = 1'b1; iaddr[31:0] = 32'h100; ramstate = BUSY;
    step();
    chk("A_ramaddr", 64'(ramaddr), 64'h100);
    chk("A_ramREN", 64'(ramREN), 64'd1);
    chk("A_stall_iwait", 64'(iwait), 64'h3);
    step();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    chk("A_iwait_pulse", 64'(iwait), 64'h2);
    chk("A_iload", 64'(iload[31:0]), 64'hDEADBEEF);
    step();
    iREN[0] = 1'b0; ramstate = FREE;
    chk("A_iwait_after", 64'(iwait), 64'h3);
    step();

    // Reset in the middle of a stalled access.
    dREN[1] = 1'b1; daddr[63:32] = 32'h80; ramstate = BUSY;
    step();
    chk("R_busy_ren", 64'(ramREN), 64'd1);
    RST = 1'b1;
    #1;
    chk("R_ramREN", 64'(ramREN), 64'd0);
    chk("R_iwait", 64'(iwait), 64'h3);
    chk("R_dwait", 64'(dwait), 64'h3);
    RST = 1'b0;
    owner = -1; m_ptr = 0;
    iREN[0] = 1'b1; iaddr[31:0] = 32'h200;
    step();
    chk("R_grant_from0", 64'(ramaddr), 64'h200);
    clear_inputs();
    step();

    // All four requesters held high, RAM completes every BUSY cycle.
    do_reset();
    dREN = '1; iREN = '1;
    daddr = {32'h1010, 32'h1000}; iaddr = {32'h2010, 32'h2000};
    ramstate = ACCESS;
    pulse_log.delete();
    for (int k = 0; k < 10; k++) step();
    chk("B_npulses", 64'(pulse_log.size()), 64'd5);
    if (pulse_log.size() >= 5) begin
      chk("B_order0", 64'(pulse_log[0]), 64'd0);
      chk("B_order1", 64'(pulse_log[1]), 64'd1);
      chk("B_order2", 64'(pulse_log[2]), 64'd2);
      chk("B_order3", 64'(pulse_log[3]), 64'd3);
      chk("B_wrap", 64'(pulse_log[4]), 64'd0);
    end
    clear_inputs();
    step();

    // Read and write both raised on CPU 1 data side: write wins.
    dREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[63:32] = 32'h40; dstore[63:32] = 32'h55;
    step();
    chk("C_ramWEN", 64'(ramWEN), 64'd1);
    chk("C_ramREN", 64'(ramREN), 64'd0);
    chk("C_ramstore", 64'(ramstore), 64'h55);
    chk("C_ramaddr", 64'(ramaddr), 64'h40);
    ramstate = ACCESS;
    #1;
    chk("C_dwait_pulse", 64'(dwait), 64'h1);
    step();
    clear_inputs();
    step();

    // Abort: granted iREN[1] dropped, pending dREN[0] served next.
    do_reset();
    dREN[0] = 1'b1; daddr[31:0] = 32'h400; ramstate = ACCESS;
    step();
    step();
    iREN[1] = 1'b1; iaddr[63:32] = 32'h300; ramstate = BUSY;
    pulse_log.delete();
    step();
    chk("D_grant3", 64'(ramaddr), 64'h300);
    step();
    iREN[1] = 1'b0;
    #1;
    chk("D_no_pulse", 64'(iwait), 64'h3);
    step();
    chk("D_idle_ren", 64'(ramREN), 64'd0);
    step();
    chk("D_next_grant", 64'(ramaddr), 64'h400);
    chk("D_log_empty", 64'(pulse_log.size()), 64'd0);
    ramstate = ACCESS;
    step();
    clear_inputs();
    step();

`ifdef MEMARB_DPRIO_EN
    do_reset();
    iREN = '1; dREN[1] = 1'b1;
    iaddr = {32'h510, 32'h500}; daddr[63:32] = 32'h520;
    step();
    chk("P_data_first", 64'(ramaddr), 64'h520);
    clear_inputs();
    step();
    step();
`endif

    // Randomised traffic against the reference.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(3) == 0) iREN[c] = ~iREN[c];
        if ($urandom_range(3) == 0) dREN[c] = ~dREN[c];
        if ($urandom_range(5) == 0) dWEN[c] = ~dWEN[c];
      end
      iaddr   = {$urandom, $urandom};
      daddr   = {$urandom, $urandom};
      dstore  = {$urandom, $urandom};
      ramload = $urandom;
      ramstate = ($urandom_range(1) == 1) ? 2'(ACCESS) : 2'($urandom_range(3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
